// File: rtl/stream_demux_1to2_if.sv
// ----------------------------------------------------------------------------
// stream_demux_1to2_if
//   Bundles the producer-side stream, both consumer-side streams and the
//   per-channel accepted-word counters of the 1-to-2 stream demux.
//
//   Producer side : data_i, valid_i, select_i -> ready_o
//   Channel 0     : data0_o, valid0_o <- ready0_i
//   Channel 1     : data1_o, valid1_o <- ready1_i
//   Counters      : count0_o, count1_o
//
//   slave  : view used by the demux itself
//   master : view used by the surrounding producer/consumers
// ----------------------------------------------------------------------------
interface stream_demux_1to2_if #(
  parameter int size  = 32,
  parameter int CNT_W = 16
);
  logic [size-1:0]  data_i;
  logic             valid_i;
  logic             select_i;
  logic             ready_o;
  logic [size-1:0]  data0_o;
  logic             valid0_o;
  logic             ready0_i;
  logic [size-1:0]  data1_o;
  logic             valid1_o;
  logic             ready1_i;
  logic [CNT_W-1:0] count0_o;
  logic [CNT_W-1:0] count1_o;

  modport slave (
    input  data_i, valid_i, select_i, ready0_i, ready1_i,
    output ready_o, data0_o, valid0_o, data1_o, valid1_o, count0_o, count1_o
  );

  modport master (
    output data_i, valid_i, select_i, ready0_i, ready1_i,
    input  ready_o, data0_o, valid0_o, data1_o, valid1_o, count0_o, count1_o
  );
endinterface

// File: rtl/stream_demux_1to2.sv
// ----------------------------------------------------------------------------
// stream_demux_1to2
//   Buffered 1-to-2 stream steering. Each word accepted on the input stream
//   is written into the 2-entry FIFO of the channel chosen by select_i at
//   acceptance. Each channel drains independently, so a stalled consumer only
//   blocks words bound for its own channel once that FIFO is full.
//
//   Ports:
//     clk_i  - clock, rising edge
//     rst_i  - asynchronous active-low reset
//     bus    - stream_demux_1to2_if.slave (input stream, two output streams,
//              per-channel accepted-word counters)
//
//   Latency is one cycle (no bypass from data_i to the outputs); throughput
//   is one word per cycle per channel.
// ----------------------------------------------------------------------------
module stream_demux_1to2 #(
  parameter int size  = 32,
  parameter int CNT_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  stream_demux_1to2_if.slave    bus
);

  // Storage and state, indexed [channel] (and [entry] for storage).
  logic [size-1:0]  r_mem   [2][2];
  logic [1:0]       r_rd_ptr;
  logic [1:0]       r_wr_ptr;
  logic [1:0]       r_occ   [2];
  logic [CNT_W-1:0] r_count [2];

  logic [1:0]       w_full;
  logic [1:0]       w_empty;
  logic [1:0]       w_push;
  logic [1:0]       w_pop;
  logic [1:0]       w_cons_ready;
  logic             w_ready;

  assign w_cons_ready = {bus.ready1_i, bus.ready0_i};

  // NOTE: every signal written here gets a value on every path, so no latch
  // can be inferred.
  always_comb begin
    w_full  = '0;
    w_empty = '0;
    w_push  = '0;
    w_pop   = '0;
    for (int c = 0; c < 2; c++) begin
      w_full[c]  = (r_occ[c] == 2'd2);
      w_empty[c] = (r_occ[c] == 2'd0);
      w_pop[c]   = ~w_empty[c] & w_cons_ready[c];
    end
    // Producer ready looks only at registered occupancy, never at consumer
    // ready, so a full FIFO cannot accept in the cycle it drains.
    w_ready   = bus.select_i ? ~w_full[1] : ~w_full[0];
    w_push[0] = bus.valid_i & w_ready & ~bus.select_i;
    w_push[1] = bus.valid_i & w_ready &  bus.select_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      // NOTE: the FIFO storage is reset as well so the data outputs read 0
      // straight out of reset instead of undefined contents.
      for (int c = 0; c < 2; c++) begin
        for (int e = 0; e < 2; e++) begin
          r_mem[c][e] <= '0;
        end
        r_occ[c]   <= '0;
        r_count[c] <= '0;
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update based on
      // the pre-edge values regardless of statement order.
      for (int c = 0; c < 2; c++) begin
        if (w_push[c]) begin
          r_mem[c][r_wr_ptr[c]] <= bus.data_i;
          r_wr_ptr[c]           <= ~r_wr_ptr[c];
          r_count[c]            <= r_count[c] + CNT_W'(1);
        end
        if (w_pop[c]) begin
          r_rd_ptr[c] <= ~r_rd_ptr[c];
        end
        case ({w_push[c], w_pop[c]})
          2'b10:   r_occ[c] <= r_occ[c] + 2'd1;
          2'b01:   r_occ[c] <= r_occ[c] - 2'd1;
          default: r_occ[c] <= r_occ[c];
        endcase
      end
    end
  end

  // When a FIFO is empty its last-popped word sits just behind the read
  // pointer; showing that slot keeps the data output holding its last value.
  // The next push lands at the read pointer, so that slot is undisturbed.
  assign bus.ready_o  = w_ready;
  assign bus.valid0_o = ~w_empty[0];
  assign bus.valid1_o = ~w_empty[1];
  assign bus.data0_o  = w_empty[0] ? r_mem[0][~r_rd_ptr[0]] : r_mem[0][r_rd_ptr[0]];
  assign bus.data1_o  = w_empty[1] ? r_mem[1][~r_rd_ptr[1]] : r_mem[1][r_rd_ptr[1]];
  assign bus.count0_o = r_count[0];
  assign bus.count1_o = r_count[1];

endmodule

// File: tb/tb_stream_demux_1to2.sv
// ----------------------------------------------------------------------------
// tb_stream_demux_1to2
//   Directed stimulus with a per-channel scoreboard. The driver pushes the
//   hand-expected word into the channel queue whenever it expects acceptance;
//   an independent monitor pops and compares on every output handshake.
// ----------------------------------------------------------------------------
module tb_stream_demux_1to2;
  localparam int SIZE = 32;
  localparam int CW   = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_demux_1to2_if #(.size(SIZE), .CNT_W(CW)) bus ();

  stream_demux_1to2 #(.size(SIZE), .CNT_W(CW)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [SIZE-1:0] exp_q0[$];
  logic [SIZE-1:0] exp_q1[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: outputs are stable at the falling edge, and a handshake seen
  // there is exactly the one taken at the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.valid0_o && bus.ready0_i) begin
        if (exp_q0.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL ch0 unexpected word: got 0x%0h, none expected", bus.data0_o);
        end else begin
          check("ch0 data", bus.data0_o, exp_q0.pop_front());
        end
      end
      if (bus.valid1_o && bus.ready1_i) begin
        if (exp_q1.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL ch1 unexpected word: got 0x%0h, none expected", bus.data1_o);
        end else begin
          check("ch1 data", bus.data1_o, exp_q1.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // One input beat. exp_acc is the hand-expected ready_o. When chk_en is set,
  // the output of channel chk_ch is also required to show chk_data as valid
  // during this beat.
  task automatic push(input logic [SIZE-1:0] d, input logic sel, input logic exp_acc,
                      input string name, input logic chk_en = 1'b0,
                      input logic chk_ch = 1'b0, input logic [SIZE-1:0] chk_data = '0);
    bus.valid_i  = 1'b1;
    bus.data_i   = d;
    bus.select_i = sel;
    @(negedge clk);
    check(name, bus.ready_o, exp_acc);
    if (chk_en) begin
      check({name, " out valid"}, chk_ch ? bus.valid1_o : bus.valid0_o, 1'b1);
      check({name, " out data"},  chk_ch ? bus.data1_o  : bus.data0_o,  chk_data);
    end
    if (exp_acc) begin
      if (sel) exp_q1.push_back(d);
      else     exp_q0.push_back(d);
    end
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
  endtask

  task automatic do_reset();
    bus.valid_i = 1'b0;
    rst_n = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    bus.valid_i = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.valid_i  = 1'b0;
    bus.data_i   = '0;
    bus.select_i = 1'b0;
    bus.ready0_i = 1'b0;
    bus.ready1_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset valid0", bus.valid0_o, 1'b0);
    check("reset count0", bus.count0_o, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ---- asynchronous reset mid-stream ----
    push(32'h1, 1'b0, 1'b1, "rst fill0a");
    push(32'h2, 1'b0, 1'b1, "rst fill0b");
    push(32'h7, 1'b1, 1'b1, "rst fill1a");
    #3;
    check("pre-rst count0", bus.count0_o, 16'd2);
    check("pre-rst count1", bus.count1_o, 16'd1);
    check("pre-rst data0",  bus.data0_o, 32'h1);
    check("pre-rst full",   bus.ready_o, 1'b1);  // select_i = 1, ch1 holds one word
    rst_n = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    #1;
    check("async rst valid0", bus.valid0_o, 1'b0);
    check("async rst valid1", bus.valid1_o, 1'b0);
    check("async rst data0",  bus.data0_o, 32'h0);
    check("async rst data1",  bus.data1_o, 32'h0);
    check("async rst count0", bus.count0_o, 16'h0);
    check("async rst count1", bus.count1_o, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus.ready1_i = 1'b1;
    push(32'hA5A5_A5A5, 1'b1, 1'b1, "post-rst push");
    @(negedge clk);
    check("post-rst valid1", bus.valid1_o, 1'b1);
    check("post-rst data1",  bus.data1_o, 32'hA5A5_A5A5);
    @(posedge clk); #1;
    idle(2);

    // ---- steering ----
    do_reset();
    bus.ready0_i = 1'b1;
    bus.ready1_i = 1'b1;
    push(32'h11, 1'b0, 1'b1, "steer 11");
    push(32'h22, 1'b1, 1'b1, "steer 22", 1'b1, 1'b0, 32'h11);
    push(32'h33, 1'b0, 1'b1, "steer 33", 1'b1, 1'b1, 32'h22);
    push(32'h44, 1'b1, 1'b1, "steer 44", 1'b1, 1'b0, 32'h33);
    @(negedge clk);
    check("steer 44 valid1", bus.valid1_o, 1'b1);
    check("steer 44 data1",  bus.data1_o, 32'h44);
    check("steer count0", bus.count0_o, 16'd2);
    check("steer count1", bus.count1_o, 16'd2);
    @(posedge clk); #1;
    idle(2);
    check("steer drained valid0", bus.valid0_o, 1'b0);
    check("steer hold data0", bus.data0_o, 32'h33);

    // ---- backpressure isolation ----
    do_reset();
    bus.ready0_i = 1'b0;
    bus.ready1_i = 1'b1;
    push(32'h1, 1'b0, 1'b1, "bp push1");
    push(32'h2, 1'b0, 1'b1, "bp push2", 1'b1, 1'b0, 32'h1);
    push(32'h3, 1'b0, 1'b0, "bp push3 refused", 1'b1, 1'b0, 32'h1);
    @(negedge clk);
    check("bp count0", bus.count0_o, 16'd2);
    @(posedge clk); #1;
    push(32'h9, 1'b1, 1'b1, "bp push9 ch1", 1'b1, 1'b0, 32'h1);
    @(negedge clk);
    check("bp valid1", bus.valid1_o, 1'b1);
    check("bp data1",  bus.data1_o, 32'h9);
    check("bp count1", bus.count1_o, 16'd1);
    @(posedge clk); #1;

    // ---- full plus pop: ch0 still holds 0x1, 0x2 ----
    bus.ready0_i = 1'b1;
    push(32'h3, 1'b0, 1'b0, "fp refuse while draining", 1'b1, 1'b0, 32'h1);
    push(32'h3, 1'b0, 1'b1, "fp accept", 1'b1, 1'b0, 32'h2);
    @(negedge clk);
    check("fp data0 3", bus.data0_o, 32'h3);
    check("fp count0",  bus.count0_o, 16'd3);
    @(posedge clk); #1;
    idle(2);

    // ---- counter wrap on ch1 ----
    do_reset();
    bus.ready0_i = 1'b1;
    bus.ready1_i = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      push(SIZE'(i), 1'b1, 1'b1, "wrap preload");
    end
    @(negedge clk);
    check("wrap count1 ffff", bus.count1_o, 16'hFFFF);
    check("wrap count0 pre",  bus.count0_o, 16'h0);
    @(posedge clk); #1;
    push(32'hDEAD_BEEF, 1'b1, 1'b1, "wrap last");
    @(negedge clk);
    check("wrap count1 0", bus.count1_o, 16'h0);
    check("wrap count0 post", bus.count0_o, 16'h0);
    @(posedge clk); #1;
    idle(3);

    // ---- idle inputs ----
    for (int i = 0; i < 20; i++) begin
      bus.valid_i  = 1'b0;
      bus.select_i = 1'($urandom);
      bus.data_i   = $urandom;
      @(negedge clk);
      check("idle valid0", bus.valid0_o, 1'b0);
      check("idle valid1", bus.valid1_o, 1'b0);
      @(posedge clk); #1;
    end
    check("idle count0", bus.count0_o, 16'h0);
    check("idle count1", bus.count1_o, 16'h0);

    idle(2);
    check("sb ch0 drained", exp_q0.size(), 0);
    check("sb ch1 drained", exp_q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/stream_demux_1to2.md
Name: stream_demux_1to2

Overview:
- Buffered 1-to-2 steering block: the inverse of the 2-to-1 select path.
- Takes one valid/ready input stream and routes each accepted word to output channel 0 or 1 according to select_i sampled at acceptance.
- Each channel has its own 2-entry FIFO, so one stalled consumer does not block words bound for the other while that channel has space.
- Used in the datapath to split result/write-back traffic between two consumers.

Parameters:
- size, 32, data word width in bits.
- CNT_W, 16, width of the per-channel accepted-word counters.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous active-low reset.
- data_i  input  size  input word.
- valid_i  input  1  input word valid.
- select_i  input  1  destination of the current input word: 0 = channel 0, 1 = channel 1.
- ready_o  output  1  input accepted this cycle when valid_i && ready_o.
- data0_o  output  size  channel 0 head word.
- valid0_o  output  1  channel 0 head valid.
- ready0_i  input  1  channel 0 consumer ready.
- data1_o  output  size  channel 1 head word.
- valid1_o  output  1  channel 1 head valid.
- ready1_i  input  1  channel 1 consumer ready.
- count0_o  output  CNT_W  words accepted for channel 0.
- count1_o  output  CNT_W  words accepted for channel 1.

Behaviour:
- Reset (rst_i low, asynchronous, any time):
  - both FIFOs empty; all FIFO storage cleared to 0.
  - valid0_o = valid1_o = 0; data0_o = data1_o = 0; count0_o = count1_o = 0.
  - Any word in flight or buffered is discarded.
  - Release is synchronous to the next rising edge.
- Per-channel FIFO:
  - 2 entries; read pointer, write pointer, 2-bit occupancy (0..2).
  - Pointers wrap 1 -> 0.
  - full = occupancy 2; empty = occupancy 0.
- ready_o:
  - Combinational: select_i ? ~full1 : ~full0.
  - Depends only on select_i and registered occupancy, never on ready0_i or ready1_i, so there is no combinational path from consumer ready to producer ready.
- Push:
  - When valid_i && ready_o, data_i is written into the FIFO selected by select_i at the write pointer.
  - That FIFO's write pointer advances and its count increments by 1, wrapping at 2^CNT_W (0xFFFF + 1 -> 0x0000 at default).
- Pop:
  - When validN_o && readyN_i, the head is consumed and the read pointer advances.
  - dataN_o = entry at the read pointer while validN_o is 1; it holds its last value when empty.
  - validN_o = ~emptyN.
- Latency:
  - Minimum 1 cycle: a word accepted at edge k is visible on dataN_o/validN_o after edge k.
  - There is no same-cycle bypass from data_i to the outputs.
- Throughput: 1 word per cycle per channel when the consumer holds readyN_i high.
- Ordering: strict FIFO order within each channel; no ordering relation between channels.
- Simultaneous push and pop, same channel:
  - occupancy 1: occupancy stays 1; the new word becomes the head on the next cycle.
  - occupancy 0: no pop is possible; push only.
  - occupancy 2: push is blocked because ready_o is low; pop proceeds and occupancy becomes 1. A full FIFO never accepts in the same cycle it drains.
- Simultaneous push to one channel and pop from the other: independent, both take effect.
- valid_i low: no push, counters unchanged, whatever the values of select_i and data_i.
- AXI-style output obligation: once validN_o is high, dataN_o is stable until popped.
- No input-side stability obligation: the producer may drop valid_i or change select_i while ready_o is low.

Test Plan:
- Reset:
  - Drive rst_i low mid-stream with channel 0 holding 2 words and channel 1 holding 1 word.
  - Required: valid0_o = valid1_o = 0, data outputs 0, counts 0 immediately, without waiting for a clock edge.
  - After release, a push of 0xA5A5A5A5 to channel 1 appears with valid1_o = 1 one cycle later.
- Steering:
  - ready0_i = ready1_i = 1; push 0x11, 0x22, 0x33, 0x44 with select pattern 0, 1, 0, 1 on consecutive cycles.
  - Required: channel 0 outputs 0x11 then 0x33, channel 1 outputs 0x22 then 0x44, each 1 cycle after acceptance.
  - Required: count0_o = count1_o = 2; ready_o stays high throughout.
- Backpressure isolation:
  - Hold ready0_i = 0; push 0x1, 0x2, 0x3 to channel 0.
  - Required: 0x3 is not accepted (ready_o = 0) and count0_o = 2.
  - Then push 0x9 to channel 1: accepted, and appears on data1_o the next cycle.
- Full plus pop:
  - Channel 0 full with 0x1, 0x2; raise ready0_i while offering 0x3 with select_i = 0.
  - Required: that cycle 0x1 pops and 0x3 is refused.
  - Next cycle 0x3 is accepted; the channel 0 output sequence is 0x1, 0x2, 0x3.
- Counter wrap:
  - Preload via 65535 pushes to channel 1 with ready1_i = 1, then 1 more.
  - Required: count1_o goes 0xFFFF -> 0x0000; count0_o is unchanged.
- Idle inputs:
  - valid_i = 0 while toggling select_i and data_i randomly for 20 cycles.
  - Required: no valid outputs, counts unchanged.
